// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: D-stage source reads, per-stage destination
// writes, memory busy and redirect on one side; forward selects, stage
// stall/flush controls and the stall counter on the other.
interface hazard_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int CNT_W     = 32
);
  logic                        jump;
  logic                        rs1ReadEnable;
  logic                        rs2ReadEnable;
  logic [REG_AW-1:0]           rs1ReadAddr;
  logic [REG_AW-1:0]           rs2ReadAddr;
  logic [FWD_DEPTH-1:0]        rdWriteEn;
  logic [FWD_DEPTH*REG_AW-1:0] rdWriteAddr;
  logic                        rdIsLoad;
  logic                        memBusy;

  logic [FWD_DEPTH-1:0]        Redirect1;
  logic [FWD_DEPTH-1:0]        Redirect2;
  logic                        stallF;
  logic                        stallD;
  logic                        stallE;
  logic                        flushF;
  logic                        flushD;
  logic                        flushE;
  logic [CNT_W-1:0]            stallCycles;

  // Pipeline side: supplies operand/destination info, consumes controls.
  modport master (
    output jump, rs1ReadEnable, rs2ReadEnable, rs1ReadAddr, rs2ReadAddr,
           rdWriteEn, rdWriteAddr, rdIsLoad, memBusy,
    input  Redirect1, Redirect2, stallF, stallD, stallE,
           flushF, flushD, flushE, stallCycles
  );

  // Hazard unit side.
  modport slave (
    input  jump, rs1ReadEnable, rs2ReadEnable, rs1ReadAddr, rs2ReadAddr,
           rdWriteEn, rdWriteAddr, rdIsLoad, memBusy,
    output Redirect1, Redirect2, stallF, stallD, stallE,
           flushF, flushD, flushE, stallCycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for an in-order pipeline: operand forwarding select,
// load-use bubbles, memory-wait freeze and branch/jump flush, plus a
// saturating count of fetch-stall cycles.
// LOAD_LAT is expected to lie in 1..FWD_DEPTH-1.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FWD_DEPTH   = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int LCW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [LCW-1:0] LCNT_LOAD = LCW'((LOAD_LAT > 0) ? (LOAD_LAT - 1) : 0);
  localparam logic [LCW-1:0] LCNT_ONE  = LCW'(1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDWAIT  = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [LCW-1:0]       lcnt_reg, lcnt_next;

  logic [FWD_DEPTH-1:0] match1, match2;
  logic [FWD_DEPTH-1:0] sel1, sel2;
  logic [FWD_DEPTH-1:0] redirect1_reg, redirect2_reg;
  logic [CNT_W-1:0]     stall_cnt_reg;

  logic                 load_use;
  logic                 in_ldwait;
  logic                 stall_f, stall_d, stall_e;
  logic                 flush_f, flush_d, flush_e;

  // Per-stage source match against each in-flight destination.
  for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_stage
    logic [REG_AW-1:0] dst;
    logic              dst_ok;

    assign dst        = hz.rdWriteAddr[gi*REG_AW +: REG_AW];
    assign dst_ok     = hz.rdWriteEn[gi] && ((ZERO_REG_EN == 0) || (dst != '0));
    assign match1[gi] = dst_ok && hz.rs1ReadEnable && (hz.rs1ReadAddr == dst);
    assign match2[gi] = dst_ok && hz.rs2ReadEnable && (hz.rs2ReadAddr == dst);
  end

  // Nearest stage wins: isolate the lowest set bit, giving a one-hot select.
  assign sel1 = match1 & (~match1 + FWD_DEPTH'(1));
  assign sel2 = match2 & (~match2 + FWD_DEPTH'(1));

  // A load sitting in the nearest stage cannot forward yet.
  assign load_use = hz.rdIsLoad && (match1[0] || match2[0]);

  // Leaving MEMWAIT with bubbles still owed resumes them in the same cycle,
  // so the dependent instruction never slips through a gap.
  assign in_ldwait = (state_reg == LDWAIT) ||
                     ((state_reg == MEMWAIT) && (lcnt_reg != '0));

  // Stage controls and next-state selection; memBusy > jump > load bubbles.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_f    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    state_next = state_reg;
    lcnt_next  = lcnt_reg;

    if (!rst) begin
      state_next = RUN;
      lcnt_next  = '0;
    end else if (hz.memBusy) begin
      // Freeze the whole front end; owed bubbles wait in lcnt.
      stall_f    = 1'b1;
      stall_d    = 1'b1;
      stall_e    = 1'b1;
      state_next = MEMWAIT;
    end else if (hz.jump) begin
      // Wrong-path instructions are discarded, pending bubbles with them.
      flush_f    = 1'b1;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      lcnt_next  = '0;
      state_next = RUN;
    end else if (in_ldwait) begin
      // lcnt holds bubbles remaining including this one.
      stall_f    = 1'b1;
      stall_d    = 1'b1;
      flush_e    = 1'b1;
      lcnt_next  = (lcnt_reg == '0) ? '0 : (lcnt_reg - LCNT_ONE);
      state_next = (lcnt_reg <= LCNT_ONE) ? RUN : LDWAIT;
    end else begin
      state_next = RUN;
      if (load_use) begin
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        flush_e    = 1'b1;
        lcnt_next  = LCNT_LOAD;
        state_next = (LOAD_LAT > 1) ? LDWAIT : RUN;
      end
    end
  end

  // FSM state and bubble counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      lcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lcnt_reg  <= lcnt_next;
    end
  end

  // Forward selects follow the D instruction into E: cleared by a bubble,
  // held while E is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect1_reg <= '0;
      redirect2_reg <= '0;
    end else if (flush_e) begin
      redirect1_reg <= '0;
      redirect2_reg <= '0;
    end else if (!stall_e) begin
      redirect1_reg <= sel1;
      redirect2_reg <= sel2;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_f && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign hz.Redirect1   = redirect1_reg;
  assign hz.Redirect2   = redirect2_reg;
  assign hz.stallF      = stall_f;
  assign hz.stallD      = stall_d;
  assign hz.stallE      = stall_e;
  assign hz.flushF      = flush_f;
  assign hz.flushD      = flush_d;
  assign hz.flushE      = flush_e;
  assign hz.stallCycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations (defaults, x0 forwarding
// allowed, deep pipe with two-cycle load latency and a 4-bit counter).
// Inputs change just after the falling edge; outputs are read 1 ns later.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .FWD_DEPTH(2), .CNT_W(32)) ia ();
  hazard_ctrl_if #(.REG_AW(5), .FWD_DEPTH(2), .CNT_W(32)) ib ();
  hazard_ctrl_if #(.REG_AW(5), .FWD_DEPTH(3), .CNT_W(4))  ic ();

  hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(32))
    u_a (.clk(clk), .rst(rst), .hz(ia));
  hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(1), .ZERO_REG_EN(0), .CNT_W(32))
    u_b (.clk(clk), .rst(rst), .hz(ib));
  hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2), .ZERO_REG_EN(1), .CNT_W(4))
    u_c (.clk(clk), .rst(rst), .hz(ic));

  // {stallF, stallD, stallE, flushF, flushD, flushE}
  logic [5:0] ctl_a, ctl_c;
  assign ctl_a = {ia.stallF, ia.stallD, ia.stallE, ia.flushF, ia.flushD, ia.flushE};
  assign ctl_c = {ic.stallF, ic.stallD, ic.stallE, ic.flushF, ic.flushD, ic.flushE};

  task automatic idle_all();
    ia.jump = 1'b0; ia.rs1ReadEnable = 1'b0; ia.rs2ReadEnable = 1'b0;
    ia.rs1ReadAddr = '0; ia.rs2ReadAddr = '0; ia.rdWriteEn = '0;
    ia.rdWriteAddr = '0; ia.rdIsLoad = 1'b0; ia.memBusy = 1'b0;
    ib.jump = 1'b0; ib.rs1ReadEnable = 1'b0; ib.rs2ReadEnable = 1'b0;
    ib.rs1ReadAddr = '0; ib.rs2ReadAddr = '0; ib.rdWriteEn = '0;
    ib.rdWriteAddr = '0; ib.rdIsLoad = 1'b0; ib.memBusy = 1'b0;
    ic.jump = 1'b0; ic.rs1ReadEnable = 1'b0; ic.rs2ReadEnable = 1'b0;
    ic.rs1ReadAddr = '0; ic.rs2ReadAddr = '0; ic.rdWriteEn = '0;
    ic.rdWriteAddr = '0; ic.rdIsLoad = 1'b0; ic.memBusy = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_all();
    nxt();
    rst = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_all();
    ic.memBusy = 1'b1;
    ic.rdIsLoad = 1'b1;
    ia.jump = 1'b1;
    nxt();
    nxt();
    $display("reset: ctl_a=%b ctl_c=%b cnt=%0d", ctl_a, ctl_c, ic.stallCycles);
    total++; if (ctl_c !== 6'b0) begin bad++; $display("FAIL reset_ctl_c: got %b want 000000", ctl_c); end
    total++; if (ctl_a !== 6'b0) begin bad++; $display("FAIL reset_ctl_a: got %b want 000000", ctl_a); end
    total++; if (ic.stallCycles !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", ic.stallCycles); end
    total++; if ({ia.Redirect1, ia.Redirect2} !== 4'b0) begin bad++; $display("FAIL reset_redir: got %b want 0000", {ia.Redirect1, ia.Redirect2}); end
    rst = 1'b1;
    idle_all();
    nxt();
    $display("reset release: ctl_c=%b cnt=%0d", ctl_c, ic.stallCycles);
    total++; if (ctl_c !== 6'b0) begin bad++; $display("FAIL release_ctl: got %b want 000000", ctl_c); end
    total++; if (ic.stallCycles !== 4'd0) begin bad++; $display("FAIL release_cnt: got %0d want 0", ic.stallCycles); end
  endtask

  task automatic test_forward();
    ia.rs1ReadEnable = 1'b1; ia.rs1ReadAddr = 5'd5;
    ia.rs2ReadEnable = 1'b1; ia.rs2ReadAddr = 5'd9;
    ia.rdWriteEn = 2'b11; ia.rdWriteAddr = {5'd5, 5'd5};
    #1;
    total++; if (ctl_a !== 6'b0) begin bad++; $display("FAIL fwd_noctl: got %b want 000000", ctl_a); end
    nxt();
    $display("forward both: r1=%b r2=%b", ia.Redirect1, ia.Redirect2);
    total++; if (ia.Redirect1 !== 2'b01) begin bad++; $display("FAIL fwd_near: got %b want 01", ia.Redirect1); end
    total++; if (ia.Redirect2 !== 2'b00) begin bad++; $display("FAIL fwd_none: got %b want 00", ia.Redirect2); end
    ia.rdWriteAddr = {5'd5, 5'd7};
    ia.rs2ReadAddr = 5'd7;
    nxt();
    $display("forward split: r1=%b r2=%b", ia.Redirect1, ia.Redirect2);
    total++; if (ia.Redirect1 !== 2'b10) begin bad++; $display("FAIL fwd_far: got %b want 10", ia.Redirect1); end
    total++; if (ia.Redirect2 !== 2'b01) begin bad++; $display("FAIL fwd_rs2: got %b want 01", ia.Redirect2); end
    idle_all();
  endtask

  task automatic test_x0();
    ia.rs1ReadEnable = 1'b1; ia.rs2ReadEnable = 1'b1; ia.rdWriteEn = 2'b11;
    ib.rs1ReadEnable = 1'b1; ib.rs2ReadEnable = 1'b1; ib.rdWriteEn = 2'b11;
    nxt();
    $display("x0: a r1=%b r2=%b  b r1=%b r2=%b", ia.Redirect1, ia.Redirect2, ib.Redirect1, ib.Redirect2);
    total++; if (ia.Redirect1 !== 2'b00) begin bad++; $display("FAIL x0_r1: got %b want 00", ia.Redirect1); end
    total++; if (ia.Redirect2 !== 2'b00) begin bad++; $display("FAIL x0_r2: got %b want 00", ia.Redirect2); end
    total++; if (ib.Redirect1 !== 2'b01) begin bad++; $display("FAIL x0_off_r1: got %b want 01", ib.Redirect1); end
    total++; if (ib.Redirect2 !== 2'b01) begin bad++; $display("FAIL x0_off_r2: got %b want 01", ib.Redirect2); end
    idle_all();
  endtask

  task automatic test_load_use();
    logic [2:0] we_t  [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    logic [5:0] exp_t [4] = '{6'b110001, 6'b110001, 6'b000000, 6'b000000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      ic.rs2ReadEnable = 1'b1; ic.rs2ReadAddr = 5'd3;
      ic.rdWriteAddr = {5'd3, 5'd3, 5'd3};
      ic.rdWriteEn = we_t[c];
      ic.rdIsLoad = (c == 0);
      #1;
      $display("load_use c%0d: ctl=%b r2=%b cnt=%0d", c, ctl_c, ic.Redirect2, ic.stallCycles);
      total++; if (ctl_c !== exp_t[c]) begin bad++; $display("FAIL lu_ctl c%0d: got %b want %b", c, ctl_c, exp_t[c]); end
      if (c == 1) begin
        total++; if (ic.Redirect2 !== 3'b000) begin bad++; $display("FAIL lu_bubble_r2: got %b want 000", ic.Redirect2); end
      end
      if (c == 3) begin
        total++; if (ic.stallCycles !== 4'd2) begin bad++; $display("FAIL lu_cnt: got %0d want 2", ic.stallCycles); end
        total++; if (ic.Redirect2 !== 3'b100) begin bad++; $display("FAIL lu_fwd_r2: got %b want 100", ic.Redirect2); end
      end
      nxt();
    end
    idle_all();
  endtask

  task automatic test_mem_busy();
    logic [2:0] we_t  [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    logic       mb_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] exp_t [6] = '{6'b110001, 6'b111000, 6'b111000, 6'b111000, 6'b110001, 6'b000000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      ic.rs2ReadEnable = 1'b1; ic.rs2ReadAddr = 5'd3;
      ic.rdWriteAddr = {5'd3, 5'd3, 5'd3};
      ic.rdWriteEn = we_t[c];
      ic.rdIsLoad = (c == 0);
      ic.memBusy = mb_t[c];
      #1;
      $display("mem_busy c%0d: mb=%b ctl=%b", c, mb_t[c], ctl_c);
      total++; if (ctl_c !== exp_t[c]) begin bad++; $display("FAIL mb_ctl c%0d: got %b want %b", c, ctl_c, exp_t[c]); end
      nxt();
    end
    $display("mem_busy: cnt=%0d", ic.stallCycles);
    total++; if (ic.stallCycles !== 4'd5) begin bad++; $display("FAIL mb_cnt: got %0d want 5", ic.stallCycles); end
    idle_all();
  endtask

  task automatic test_jump();
    do_reset();
    ic.rs2ReadEnable = 1'b1; ic.rs2ReadAddr = 5'd3;
    ic.rdWriteEn = 3'b001; ic.rdWriteAddr = {5'd0, 5'd0, 5'd3};
    ic.rdIsLoad = 1'b1; ic.jump = 1'b1;
    #1;
    $display("jump c0: ctl=%b", ctl_c);
    total++; if (ctl_c !== 6'b000111) begin bad++; $display("FAIL jump_ctl: got %b want 000111", ctl_c); end
    nxt();
    idle_all();
    #1;
    $display("jump c1: ctl=%b r2=%b", ctl_c, ic.Redirect2);
    total++; if (ctl_c !== 6'b000000) begin bad++; $display("FAIL jump_run: got %b want 000000", ctl_c); end
    total++; if (ic.Redirect2 !== 3'b000) begin bad++; $display("FAIL jump_r2: got %b want 000", ic.Redirect2); end
    nxt();
    total++; if (ic.stallCycles !== 4'd0) begin bad++; $display("FAIL jump_cnt: got %0d want 0", ic.stallCycles); end
  endtask

  task automatic test_sat_reset();
    do_reset();
    ic.rs1ReadEnable = 1'b1; ic.rs1ReadAddr = 5'd4;
    ic.rdWriteEn = 3'b001; ic.rdWriteAddr = {5'd0, 5'd0, 5'd4};
    nxt();
    total++; if (ic.Redirect1 !== 3'b001) begin bad++; $display("FAIL sat_pre_r1: got %b want 001", ic.Redirect1); end
    ic.memBusy = 1'b1;
    for (int i = 0; i < 20; i++) nxt();
    $display("saturate: cnt=%0d ctl=%b r1=%b", ic.stallCycles, ctl_c, ic.Redirect1);
    total++; if (ic.stallCycles !== 4'd15) begin bad++; $display("FAIL sat_cnt: got %0d want 15", ic.stallCycles); end
    total++; if (ic.Redirect1 !== 3'b001) begin bad++; $display("FAIL sat_hold_r1: got %b want 001", ic.Redirect1); end
    total++; if (ctl_c !== 6'b111000) begin bad++; $display("FAIL sat_ctl: got %b want 111000", ctl_c); end
    rst = 1'b0;
    #1;
    $display("reset mid-memwait: ctl=%b cnt=%0d r1=%b", ctl_c, ic.stallCycles, ic.Redirect1);
    total++; if (ctl_c !== 6'b0) begin bad++; $display("FAIL mrst_ctl: got %b want 000000", ctl_c); end
    total++; if (ic.stallCycles !== 4'd0) begin bad++; $display("FAIL mrst_cnt: got %0d want 0", ic.stallCycles); end
    total++; if (ic.Redirect1 !== 3'b000) begin bad++; $display("FAIL mrst_r1: got %b want 000", ic.Redirect1); end
    nxt();
    rst = 1'b1;
    idle_all();
    nxt();
    total++; if (ctl_c !== 6'b0) begin bad++; $display("FAIL mrst_residual: got %b want 000000", ctl_c); end
    total++; if (ic.stallCycles !== 4'd0) begin bad++; $display("FAIL mrst_cnt_after: got %0d want 0", ic.stallCycles); end
  endtask

  // Random traffic on the deep configuration against a bubble-owed model.
  task automatic test_random();
    int         bub = 0;
    int         cnt = 0;
    logic [2:0] r1 = '0;
    logic [2:0] r2 = '0;
    logic [2:0] s1, s2, we;
    logic [14:0] wa;
    logic [4:0] a1, a2, dst;
    logic       e1, e2, ld, mb, jp, lu;
    logic [5:0] exp;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      e1 = 1'($urandom_range(0, 1));
      e2 = 1'($urandom_range(0, 1));
      a1 = 5'($urandom_range(0, 3));
      a2 = 5'($urandom_range(0, 3));
      we = 3'($urandom_range(0, 7));
      wa = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ld = 1'($urandom_range(0, 1));
      mb = ($urandom_range(0, 9) < 2);
      jp = ($urandom_range(0, 9) == 0);
      ic.rs1ReadEnable = e1; ic.rs2ReadEnable = e2;
      ic.rs1ReadAddr = a1; ic.rs2ReadAddr = a2;
      ic.rdWriteEn = we; ic.rdWriteAddr = wa;
      ic.rdIsLoad = ld; ic.memBusy = mb; ic.jump = jp;

      s1 = '0; s2 = '0;
      for (int i = 0; i < 3; i++) begin
        dst = wa[i*5 +: 5];
        if (e1 && we[i] && (a1 == dst) && (dst != 5'd0) && (s1 == 3'b0)) s1 = 3'(1 << i);
        if (e2 && we[i] && (a2 == dst) && (dst != 5'd0) && (s2 == 3'b0)) s2 = 3'(1 << i);
      end
      lu = ld && (s1[0] || s2[0]);
      if (mb)                 exp = 6'b111000;
      else if (jp)            exp = 6'b000111;
      else if (bub > 0 || lu) exp = 6'b110001;
      else                    exp = 6'b000000;

      #1;
      $display("rnd %0d: mb=%b jp=%b ld=%b ctl=%b r1=%b r2=%b cnt=%0d", n, mb, jp, ld, ctl_c, ic.Redirect1, ic.Redirect2, ic.stallCycles);
      total++; if (ctl_c !== exp) begin bad++; $display("FAIL rnd_ctl %0d: got %b want %b", n, ctl_c, exp); end
      total++; if ({ic.Redirect1, ic.Redirect2} !== {r1, r2}) begin bad++; $display("FAIL rnd_redir %0d: got %b/%b want %b/%b", n, ic.Redirect1, ic.Redirect2, r1, r2); end
      total++; if (ic.stallCycles !== 4'(cnt)) begin bad++; $display("FAIL rnd_cnt %0d: got %0d want %0d", n, ic.stallCycles, cnt); end

      if (exp[5] && cnt < 15) cnt++;
      if (exp[0]) begin
        r1 = '0; r2 = '0;
      end else if (!exp[3]) begin
        r1 = s1; r2 = s2;
      end
      if (!mb) begin
        if (jp)           bub = 0;
        else if (bub > 0) bub--;
        else if (lu)      bub = 1;
      end
      nxt();
    end
    idle_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle_all();
    test_reset();
    test_forward();
    test_x0();
    test_load_use();
    test_mem_busy();
    test_jump();
    test_sat_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
